// File: rtl/otter_intr_pkg.sv
// Shared encodings for the OTTER multi-source interrupt controller.
package otter_intr_pkg;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_REQ     = 2'd1,
      ST_SERVICE = 2'd2
   } intr_state_t;

   localparam logic [1:0] REG_ENABLE  = 2'd0;
   localparam logic [1:0] REG_PENDING = 2'd1;
   localparam logic [1:0] REG_EDGE    = 2'd2;
   localparam logic [1:0] REG_CLAIM   = 2'd3;

   localparam int CLAIM_VALID_BIT = 31;

endpackage

// File: rtl/intr_sync_edge.sv
// Per-source synchroniser with one history flop for rising-edge detection.
module intr_sync_edge #(
   parameter int SYNC_STAGES = 2
) (
   input  logic clk,
   input  logic RST,
   input  logic src,
   output logic s,
   output logic rise
);

   logic [SYNC_STAGES-1:0] sync_q;
   logic                   prev_q;

   // Shift the asynchronous line through the synchroniser and keep last sample.
   always_ff @(posedge clk) begin
      if (RST) begin
         sync_q <= '0;
         prev_q <= 1'b0;
      end else begin
         sync_q <= {sync_q[SYNC_STAGES-2:0], src};
         prev_q <= sync_q[SYNC_STAGES-1];
      end
   end

   assign s    = sync_q[SYNC_STAGES-1];
   assign rise = sync_q[SYNC_STAGES-1] & ~prev_q;

endmodule

// File: rtl/otter_intr_ctrl.sv
// Prioritised multi-source interrupt controller feeding the OTTER CU_FSM.
module otter_intr_ctrl
   import otter_intr_pkg::*;
#(
   parameter int NUM_SRC     = 8,
   parameter int SYNC_STAGES = 2,
   parameter int ID_W        = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1
) (
   input  logic               clk,
   input  logic               RST,
   input  logic [NUM_SRC-1:0] src,
   input  logic               mie,
   input  logic               intr_taken,
   input  logic               mret_exec,
   input  logic               reg_sel,
   input  logic               reg_wr,
   input  logic [1:0]         reg_addr,
   input  logic [31:0]        reg_wdata,
   output logic [31:0]        reg_rdata,
   output logic               intr,
   output logic [ID_W-1:0]    claim_id,
   output logic               claim_valid
);

   logic [NUM_SRC-1:0] s_vec;
   logic [NUM_SRC-1:0] rise_vec;
   logic [NUM_SRC-1:0] pend_q;
   logic [NUM_SRC-1:0] pend_d;
   logic [NUM_SRC-1:0] enable_q;
   logic [NUM_SRC-1:0] edge_q;
   logic [NUM_SRC-1:0] req;
   logic [NUM_SRC-1:0] w1c_mask;
   logic [NUM_SRC-1:0] edge_off_mask;
   logic [NUM_SRC-1:0] mret_mask;
   logic [NUM_SRC-1:0] wdata_src;
   logic [ID_W-1:0]    win_id;
   logic               wr_en;
   intr_state_t        state_q;

   // Upper write-data bits are architecturally ignored.
   logic unused_wdata_bits;
   assign unused_wdata_bits = ^reg_wdata;

   function automatic logic [31:0] zext_src(input logic [NUM_SRC-1:0] v);
      logic [31:0] r;
      r = '0;
      r[NUM_SRC-1:0] = v;
      return r;
   endfunction

   for (genvar g = 0; g < NUM_SRC; g++) begin : g_src
      intr_sync_edge #(
         .SYNC_STAGES(SYNC_STAGES)
      ) u_sync (
         .clk  (clk),
         .RST  (RST),
         .src  (src[g]),
         .s    (s_vec[g]),
         .rise (rise_vec[g])
      );
   end

   assign wr_en     = reg_sel & reg_wr;
   assign wdata_src = reg_wdata[NUM_SRC-1:0];
   assign req       = pend_q & enable_q;

   // Fixed-priority encoder: lowest set request index wins.
   always_comb begin
      win_id = '0;
      for (int i = NUM_SRC - 1; i >= 0; i--) begin
         if (req[i]) win_id = ID_W'(i);
      end
   end

   // Next pending: level sources track s, edge sources latch rises; a rise beats any clear.
   always_comb begin
      w1c_mask      = (wr_en && reg_addr == REG_PENDING) ? wdata_src : '0;
      edge_off_mask = (wr_en && reg_addr == REG_EDGE) ? (edge_q & ~wdata_src) : '0;
      mret_mask     = '0;
      if (state_q == ST_SERVICE && mret_exec && edge_q[claim_id]) mret_mask[claim_id] = 1'b1;
      pend_d = '0;
      for (int i = 0; i < NUM_SRC; i++) begin
         if (edge_q[i])
            pend_d[i] = (pend_q[i] & ~w1c_mask[i] & ~edge_off_mask[i] & ~mret_mask[i]) | rise_vec[i];
         else
            pend_d[i] = s_vec[i];
      end
   end

   // Pending register update.
   always_ff @(posedge clk) begin
      if (RST) pend_q <= '0;
      else     pend_q <= pend_d;
   end

   // Software-writable ENABLE and EDGE registers.
   always_ff @(posedge clk) begin
      if (RST) begin
         enable_q <= '0;
         edge_q   <= '0;
      end else if (wr_en) begin
         if (reg_addr == REG_ENABLE) enable_q <= wdata_src;
         if (reg_addr == REG_EDGE)   edge_q   <= wdata_src;
      end
   end

   // Request/claim FSM with registered outputs to CU_FSM.
   always_ff @(posedge clk) begin
      if (RST) begin
         state_q     <= ST_IDLE;
         intr        <= 1'b0;
         claim_valid <= 1'b0;
         claim_id    <= '0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (mie && |req) begin
                  state_q <= ST_REQ;
                  intr    <= 1'b1;
               end
            end
            ST_REQ: begin
               if (intr_taken) begin
                  claim_id    <= win_id;
                  claim_valid <= 1'b1;
                  intr        <= 1'b0;
                  state_q     <= ST_SERVICE;
               end else if (!(|req) || !mie) begin
                  intr    <= 1'b0;
                  state_q <= ST_IDLE;
               end
            end
            ST_SERVICE: begin
               if (mret_exec) begin
                  claim_valid <= 1'b0;
                  state_q     <= ST_IDLE;
               end
            end
            default: begin
               state_q     <= ST_IDLE;
               intr        <= 1'b0;
               claim_valid <= 1'b0;
            end
         endcase
      end
   end

   // Combinational register read mux; zero when not selected.
   always_comb begin
      reg_rdata = '0;
      if (reg_sel) begin
         case (reg_addr)
            REG_ENABLE:  reg_rdata = zext_src(enable_q);
            REG_PENDING: reg_rdata = zext_src(pend_q);
            REG_EDGE:    reg_rdata = zext_src(edge_q);
            default: begin
               reg_rdata[ID_W-1:0]       = claim_id;
               reg_rdata[CLAIM_VALID_BIT] = claim_valid;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_otter_intr_ctrl.sv
// Self-checking bench for otter_intr_ctrl.
module tb_otter_intr_ctrl;

   localparam int NUM_SRC     = 8;
   localparam int SYNC_STAGES = 2;
   localparam int ID_W        = 3;

   logic               clk;
   logic               RST;
   logic [NUM_SRC-1:0] src;
   logic               mie;
   logic               intr_taken;
   logic               mret_exec;
   logic               reg_sel;
   logic               reg_wr;
   logic [1:0]         reg_addr;
   logic [31:0]        reg_wdata;
   logic [31:0]        reg_rdata;
   logic               intr;
   logic [ID_W-1:0]    claim_id;
   logic               claim_valid;

   int passed = 0;
   int total  = 0;

   logic [31:0] exp_q[$];
   string       nm_q[$];

   typedef struct {
      string       name;
      logic [1:0]  addr;
      logic [31:0] wdata;
      logic        rd_sel;
      logic [31:0] exp;
   } vec_t;

   otter_intr_ctrl #(
      .NUM_SRC(NUM_SRC),
      .SYNC_STAGES(SYNC_STAGES),
      .ID_W(ID_W)
   ) dut (
      .clk         (clk),
      .RST         (RST),
      .src         (src),
      .mie         (mie),
      .intr_taken  (intr_taken),
      .mret_exec   (mret_exec),
      .reg_sel     (reg_sel),
      .reg_wr      (reg_wr),
      .reg_addr    (reg_addr),
      .reg_wdata   (reg_wdata),
      .reg_rdata   (reg_rdata),
      .intr        (intr),
      .claim_id    (claim_id),
      .claim_valid (claim_valid)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act === exp) passed++;
      else $display("FAIL %s: got %h expected %h", nm, act, exp);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic wr(input logic [1:0] a, input logic [31:0] d);
      reg_sel = 1'b1; reg_wr = 1'b1; reg_addr = a; reg_wdata = d;
      tick();
      reg_sel = 1'b0; reg_wr = 1'b0; reg_wdata = '0;
   endtask

   task automatic rd(input logic [1:0] a, input logic sel, input logic [31:0] exp, input string nm);
      logic [31:0] e;
      string       n;
      reg_sel = sel; reg_wr = 1'b0; reg_addr = a;
      exp_q.push_back(exp);
      nm_q.push_back(nm);
      #1;
      if (exp_q.size() == 0) begin
         chk("scoreboard empty", 32'd1, 32'd0);
      end else begin
         e = exp_q.pop_front();
         n = nm_q.pop_front();
         chk(n, reg_rdata, e);
      end
      reg_sel = 1'b0;
   endtask

   initial begin
      vec_t vecs[9];
      int   n;

      vecs[0] = '{"enable_mask_upper",  2'd0, 32'hFFFF_FF0C, 1'b1, 32'h0000_000C};
      vecs[1] = '{"edge_mask_upper",    2'd2, 32'h1234_5681, 1'b1, 32'h0000_0081};
      vecs[2] = '{"claim_read_only",    2'd3, 32'hFFFF_FFFF, 1'b1, 32'h0000_0000};
      vecs[3] = '{"pending_w1c_idle",   2'd1, 32'hFFFF_FFFF, 1'b1, 32'h0000_0000};
      vecs[4] = '{"enable_clear",       2'd0, 32'h0000_0000, 1'b1, 32'h0000_0000};
      vecs[5] = '{"edge_clear",         2'd2, 32'h0000_0000, 1'b1, 32'h0000_0000};
      vecs[6] = '{"rdata_zero_unsel",   2'd0, 32'h0000_00A5, 1'b0, 32'h0000_0000};
      vecs[7] = '{"enable_a5",          2'd0, 32'h0000_00A5, 1'b1, 32'h0000_00A5};
      vecs[8] = '{"enable_zero",        2'd0, 32'h0000_0000, 1'b1, 32'h0000_0000};

      src = '0; mie = 1'b0; intr_taken = 1'b0; mret_exec = 1'b0;
      reg_sel = 1'b0; reg_wr = 1'b0; reg_addr = '0; reg_wdata = '0;

      // Reset then idle
      RST = 1'b1; src = 8'hFF;
      tick(); tick();
      RST = 1'b0;
      chk("reset intr", {31'd0, intr}, 32'd0);
      chk("reset claim_valid", {31'd0, claim_valid}, 32'd0);
      chk("reset claim_id", {29'd0, claim_id}, 32'd0);
      rd(2'd0, 1'b1, 32'd0, "reset ENABLE");
      rd(2'd1, 1'b1, 32'd0, "reset PENDING");
      rd(2'd2, 1'b1, 32'd0, "reset EDGE");
      rd(2'd3, 1'b1, 32'd0, "reset CLAIM");
      src = '0;
      for (int k = 0; k < 6; k++) tick();

      // Register table
      for (int v = 0; v < 9; v++) begin
         wr(vecs[v].addr, vecs[v].wdata);
         rd(vecs[v].addr, vecs[v].rd_sel, vecs[v].exp, vecs[v].name);
      end

      // Level priority and re-request
      wr(2'd0, 32'h0C);
      mie = 1'b1;
      src = 8'h0C;
      for (int k = 0; k < SYNC_STAGES + 1; k++) tick();
      chk("lvl intr before latency", {31'd0, intr}, 32'd0);
      tick();
      chk("lvl intr asserted", {31'd0, intr}, 32'd1);
      intr_taken = 1'b1; tick(); intr_taken = 1'b0;
      chk("lvl claim_id", {29'd0, claim_id}, 32'd2);
      chk("lvl claim_valid", {31'd0, claim_valid}, 32'd1);
      chk("lvl intr in service", {31'd0, intr}, 32'd0);
      rd(2'd3, 1'b1, 32'h8000_0002, "lvl CLAIM");
      src = 8'h04;
      mret_exec = 1'b1; tick(); mret_exec = 1'b0;
      chk("lvl claim_valid after mret", {31'd0, claim_valid}, 32'd0);
      chk("lvl intr gap cycle", {31'd0, intr}, 32'd0);
      tick();
      chk("lvl re-request", {31'd0, intr}, 32'd1);
      mie = 1'b0; tick();
      src = '0;
      wr(2'd0, 32'h0);
      for (int k = 0; k < 4; k++) tick();

      // Edge latch
      wr(2'd2, 32'h01);
      wr(2'd0, 32'h01);
      src = 8'h01; tick(); src = '0;
      for (int k = 0; k < 4; k++) tick();
      rd(2'd1, 1'b1, 32'h01, "edge PENDING latched");
      for (int k = 0; k < 3; k++) tick();
      rd(2'd1, 1'b1, 32'h01, "edge PENDING held");
      mie = 1'b1; tick();
      chk("edge intr", {31'd0, intr}, 32'd1);
      intr_taken = 1'b1; tick(); intr_taken = 1'b0;
      chk("edge claim_valid", {31'd0, claim_valid}, 32'd1);
      chk("edge claim_id", {29'd0, claim_id}, 32'd0);
      mret_exec = 1'b1; tick(); mret_exec = 1'b0;
      rd(2'd1, 1'b1, 32'h00, "edge PENDING cleared by mret");
      tick(); tick();
      chk("edge no re-request", {31'd0, intr}, 32'd0);
      mie = 1'b0;
      wr(2'd2, 32'h0);
      wr(2'd0, 32'h0);

      // Withdrawal
      wr(2'd0, 32'h20);
      mie = 1'b1;
      src = 8'h20;
      for (int k = 0; k < SYNC_STAGES + 2; k++) tick();
      chk("wd intr asserted", {31'd0, intr}, 32'd1);
      src = '0;
      n = 0;
      while (intr !== 1'b0 && n < SYNC_STAGES + 4) begin
         tick();
         n++;
      end
      chk("wd intr withdrawn", {31'd0, intr}, 32'd0);
      intr_taken = 1'b1; tick(); intr_taken = 1'b0;
      chk("wd stray take claim_valid", {31'd0, claim_valid}, 32'd0);
      chk("wd stray take intr", {31'd0, intr}, 32'd0);
      mie = 1'b0;
      wr(2'd0, 32'h0);

      // Masking
      wr(2'd0, 32'h10);
      src = 8'h10;
      for (int k = 0; k < 5; k++) tick();
      chk("mask intr with mie=0", {31'd0, intr}, 32'd0);
      rd(2'd1, 1'b1, 32'h10, "mask PENDING");
      mie = 1'b1; tick();
      chk("mask intr after mie", {31'd0, intr}, 32'd1);
      mie = 1'b0; tick();
      chk("mask intr withdrawn by mie", {31'd0, intr}, 32'd0);
      src = '0;
      wr(2'd0, 32'h0);
      for (int k = 0; k < 4; k++) tick();

      // Set-wins and mid-service reset
      wr(2'd2, 32'h01);
      src = 8'h01; tick(); src = '0; tick();
      wr(2'd1, 32'h01);
      rd(2'd1, 1'b1, 32'h01, "setwins PENDING");
      wr(2'd1, 32'h01);
      rd(2'd1, 1'b1, 32'h00, "w1c PENDING");
      src = 8'h01; tick(); src = '0;
      tick(); tick(); tick();
      rd(2'd1, 1'b1, 32'h01, "relatch PENDING");
      mie = 1'b1;
      wr(2'd0, 32'h01);
      tick();
      chk("rst pre intr", {31'd0, intr}, 32'd1);
      intr_taken = 1'b1; tick(); intr_taken = 1'b0;
      chk("rst pre claim_valid", {31'd0, claim_valid}, 32'd1);
      RST = 1'b1; tick(); RST = 1'b0;
      chk("rst claim_valid", {31'd0, claim_valid}, 32'd0);
      chk("rst intr", {31'd0, intr}, 32'd0);
      rd(2'd1, 1'b1, 32'h00, "rst PENDING");
      rd(2'd0, 1'b1, 32'h00, "rst ENABLE");
      rd(2'd2, 1'b1, 32'h00, "rst EDGE");
      rd(2'd3, 1'b1, 32'h00, "rst CLAIM");

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
